// File: rtl/debug_unlock_pkg.sv
// Shared types and sizing helpers for the debug unlock controller.
package debug_unlock_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam int BYTE_W = 8;

  // One timer serves both session and lockout, so it is sized for the longer of the two.
  function automatic int timer_width(input int session_cycles, input int lockout_cycles);
    int longest;
    longest = (session_cycles > lockout_cycles) ? session_cycles : lockout_cycles;
    return (longest > 2) ? $clog2(longest) : 1;
  endfunction

  function automatic int fail_width(input int max_fail);
    return (max_fail > 1) ? $clog2(max_fail + 1) : 1;
  endfunction

  function automatic int index_width(input int key_bytes);
    return (key_bytes > 1) ? $clog2(key_bytes) : 1;
  endfunction

endpackage

// File: rtl/dbg_down_timer.sv
// Loadable down-counter with enable and zero flag; holds at zero.
module dbg_down_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/debug_unlock_ctrl.sv
// Debug unlock: constant-time key comparison, timed session, failure lockout.
// Key handshake: a byte transfers on a cycle where key_valid and key_ready are both high.
module debug_unlock_ctrl
  import debug_unlock_pkg::*;
#(
  parameter int KEY_BYTES      = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int SESSION_CYCLES = 65536,
  localparam int FAIL_W        = fail_width(MAX_FAIL)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W*KEY_BYTES-1:0]   ref_key,
  input  logic [BYTE_W-1:0]             key_byte,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic                          dbg_allow,
  input  logic                          relock,
  input  logic                          debug_access,
  output logic                          debug_enable,
  output logic                          unlock_fail,
  output logic                          locked_out,
  output logic [FAIL_W-1:0]             fail_count
);

  localparam int TIMER_W = timer_width(SESSION_CYCLES, LOCKOUT_CYCLES);
  localparam int IDX_W   = index_width(KEY_BYTES);

  localparam logic [TIMER_W-1:0] SESSION_LOAD = TIMER_W'(SESSION_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(KEY_BYTES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT   = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W:0]    FAIL_LIMIT_X = (FAIL_W + 1)'(MAX_FAIL);

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic                mismatch, mismatch_next;
  logic [FAIL_W-1:0]   fail_count_next, fail_inc;
  logic [FAIL_W:0]     fail_plus;
  logic                timer_load, timer_enable, timer_zero;
  logic [TIMER_W-1:0]  timer_load_value;
  logic                close_req, accept, byte_bad, fail_reached;

  assign close_req    = relock | ~dbg_allow;
  assign key_ready    = ~rst & (state == LOCKED) & ~close_req;
  assign accept       = key_valid & key_ready;
  assign byte_bad     = (key_byte != ref_key[BYTE_W*int'(idx) +: BYTE_W]);
  assign fail_plus    = {1'b0, fail_count} + (FAIL_W + 1)'(1);
  assign fail_reached = (fail_plus == FAIL_LIMIT_X);
  assign fail_inc     = (fail_count == FAIL_LIMIT) ? fail_count : fail_count + FAIL_W'(1);
  assign locked_out   = (state == LOCKOUT);

  dbg_down_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(timer_load_value),
    .enable    (timer_enable),
    .zero      (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOCKED;
      idx          <= '0;
      mismatch     <= 1'b0;
      fail_count   <= '0;
      debug_enable <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      mismatch     <= mismatch_next;
      fail_count   <= fail_count_next;
      debug_enable <= (state_next == UNLOCKED);
    end
  end

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    mismatch_next    = mismatch;
    fail_count_next  = fail_count;
    timer_load       = 1'b0;
    timer_load_value = SESSION_LOAD;
    timer_enable     = 1'b0;
    unlock_fail      = 1'b0;

    case (state)
      LOCKED: begin
        if (close_req) begin
          idx_next      = '0;
          mismatch_next = 1'b0;
        end else if (accept) begin
          // Every byte is consumed even after a mismatch so timing leaks nothing.
          mismatch_next = mismatch | byte_bad;
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            state_next = CHECK;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end

      CHECK: begin
        mismatch_next = 1'b0;
        idx_next      = '0;
        if (mismatch) begin
          unlock_fail     = 1'b1;
          fail_count_next = fail_inc;
          if (fail_reached) begin
            state_next       = LOCKOUT;
            timer_load       = 1'b1;
            timer_load_value = LOCKOUT_LOAD;
          end else begin
            state_next = LOCKED;
          end
        end else if (close_req) begin
          state_next = LOCKED;
        end else begin
          state_next      = UNLOCKED;
          fail_count_next = '0;
          timer_load      = 1'b1;
        end
      end

      UNLOCKED: begin
        if (close_req) begin
          state_next = LOCKED;
        end else if (debug_access) begin
          timer_load = 1'b1;
        end else if (timer_zero) begin
          state_next = LOCKED;
        end else begin
          timer_enable = 1'b1;
        end
      end

      LOCKOUT: begin
        if (timer_zero) begin
          state_next      = LOCKED;
          fail_count_next = '0;
        end else begin
          timer_enable = 1'b1;
        end
      end

      default: begin
        state_next = LOCKED;
      end
    endcase
  end

endmodule
